mux_bus_arbiter: RTL
====================

// Module: mux_bus_arbiter
// PURPOSE
//  Shares one 16-bit 2:1 datapath mux between two requesters, A and B.
//  - Round-robin arbitration with optional locked bursts.
//  - Drives sel_mux for the shared mux and registers the selected beat into
//    a single valid/ready output stage.
//  - Sits between two producers (e.g. ALU result path and load/immediate
//    path) and the writeback or operand bus.
// PARAMETERS
//  DATA_W     16  width of request and output data
//  MAX_BURST  4   max consecutive beats one locked owner may send (>=1;
//                 1 = lock ignored)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  a_valid    in   1       requester A has a beat
//  a_data     in   DATA_W  requester A data
//  a_lock     in   1       A requests to keep grant after this beat
//  a_ready    out  1       A beat accepted this cycle (a_valid&&a_ready)
//  b_valid    in   1       requester B has a beat
//  b_data     in   DATA_W  requester B data
//  b_lock     in   1       B requests to keep grant after this beat
//  b_ready    out  1       B beat accepted this cycle
//  sel_mux    out  1       0 = select A, 1 = select B (shared mux select)
//  out_valid  out  1       output beat valid
//  out_ready  in   1       consumer accepts output beat
//  out_data   out  DATA_W  registered selected data
//  out_src    out  1       source of out_data: 0 = A, 1 = B
//  busy       out  1       state != ARB_IDLE || out_valid
// BEHAVIOUR
//  - Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  - Reset values: out_valid=0, out_data=0, out_src=0, state=ARB_IDLE,
//    last=B (so A wins the first tie), burst_cnt=0.
//    Combinational outputs at reset: a_ready=b_ready=0, sel_mux=0.
//  - load_ok = !out_valid || out_ready. Output stage updates only when
//    load_ok.
//  - grant (combinational):
//    - ARB_IDLE: only A valid -> A; only B valid -> B; both valid -> the
//      one != last.
//    - ARB_LOCK_A -> A only. ARB_LOCK_B -> B only.
//  - sel_mux = (grant==B). When no grant, sel_mux holds its previous value.
//  - Ready: a_ready = grant==A && a_valid && load_ok; b_ready likewise.
//  - Accepted beat X:
//    - out_data <= X data, out_src <= X, out_valid <= 1.
//    - Latency: exactly 1 cycle from accept to out_valid.
//  - If out_ready && !accept: out_valid <= 0.
//  - State transitions on accept of X:
//    - If X_lock && burst_cnt < MAX_BURST-1: state <= LOCK_X,
//      burst_cnt++.
//    - Otherwise: state <= ARB_IDLE, burst_cnt <= 0, last <= X.
//  - In LOCK_X with X_valid=0: state <= ARB_IDLE next cycle,
//    burst_cnt <= 0, last <= X. No accept happens that cycle, and the
//    other requester is not granted that cycle.
//  - Backpressure: out_valid && !out_ready forces both readys to 0.
//    State, burst_cnt, last and out_* are held. A request withdrawn during
//    a stall is legal; no beat is lost.
//  - Burst cap reached: grant is released even if lock is still high; the
//    other requester wins the next tie.
//  - rst mid-burst or mid-stall: all state returns to reset values next
//    edge, and any pending output beat is dropped.
//  - No combinational path from out_ready to out_data.
// STRUCTURE
//  - Package mux_arb_pkg:
//    - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_LOCK_A,
//      ARB_LOCK_B}
//    - typedef enum logic src_t {SRC_A=1'b0, SRC_B=1'b1}
//    - localparam DATA_W_DEF=16
//  - Sub-module arb_out_stage: the valid/ready output register
//    (load_ok, out_valid/out_data/out_src).
//  - Arbiter FSM, burst counter and data mux stay in mux_bus_arbiter.
// TESTING
//  1. Reset: assert rst 2 cycles with a_valid=b_valid=1
//     -> out_valid=0, readys=0, sel_mux=0.
//     After release the first grant is A.
//  2. Round-robin: a_valid=b_valid=1, locks=0, out_ready=1,
//     a_data=16'h1111, b_data=16'h2222 -> out_data sequence 1111,2222,
//     1111,2222 with out_src 0,1,0,1 and sel_mux toggling each cycle.
//  3. Locked burst: MAX_BURST=4, a_lock=1 held, b_valid=1 -> exactly 4
//     A beats back-to-back (b_ready=0 throughout), then one B beat.
//  4. Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=16'hBEEF
//     -> out_data stays BEEF, readys=0.
//     Then out_ready=1 -> next beat accepted 1 cycle later.
//  5. Lock drop: A in LOCK_A deasserts a_valid -> next cycle state=IDLE,
//     and a pending B is granted the cycle after.
//  6. Reset mid-burst: rst during beat 2 of an A burst -> out_valid=0 next
//     cycle, burst_cnt=0, and the next tie goes to A.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester mux arbiter.
// Latency: none; this file holds types and constants only.
// Backpressure: not applicable.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_A = 2'd1,
        ARB_LOCK_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    localparam int DATA_W_DEF = 16;

    // Round-robin tie-break: the requester that did not win last time.
    function automatic src_t other_src(input src_t s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/arb_out_stage.sv
// Single-entry valid/ready output register for the arbiter's selected beat.
// Latency: 1 cycle from load to out_valid.
// Backpressure: load_ok is low while a beat is held and out_ready is low.
// Ports: clk/rst; load, load_data, load_src (accepted beat); out_ready;
//        load_ok (stage can take a beat); out_valid, out_data, out_src.
module arb_out_stage
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_src,
    input  logic              out_ready,
    output logic              load_ok,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);

    // out_ready only affects load_ok; out_data is purely registered.
    assign load_ok = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_A;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_src   <= load_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for a shared 2:1 datapath mux with optional locked bursts.
// Latency: 1 cycle from accept (x_valid && x_ready) to out_valid.
// Backpressure: a held, unaccepted output beat drops both readys and freezes arbitration.
// Ports: clk, rst; a_/b_ valid, data, lock in, ready out; sel_mux; out_valid,
//        out_ready, out_data, out_src; busy.
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_lock,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_lock,
    output logic              b_ready,
    output logic              sel_mux,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        state;
    src_t              last;
    logic [CNT_W-1:0]  burst_cnt;
    logic              sel_q;

    logic              grant_vld;
    src_t              grant_src;
    logic              load_ok;
    logic              accept;
    src_t              acc_src;
    logic              acc_lock;
    logic [DATA_W-1:0] mux_data;

    // A locked owner keeps the grant even while it has no beat; the other
    // requester must wait for the lock to be released.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_A;
        case (state)
            ARB_IDLE: begin
                if (a_valid && b_valid) begin
                    grant_vld = 1'b1;
                    grant_src = other_src(last);
                end else if (a_valid) begin
                    grant_vld = 1'b1;
                    grant_src = SRC_A;
                end else if (b_valid) begin
                    grant_vld = 1'b1;
                    grant_src = SRC_B;
                end
            end
            ARB_LOCK_A: begin
                grant_vld = a_valid;
                grant_src = SRC_A;
            end
            ARB_LOCK_B: begin
                grant_vld = b_valid;
                grant_src = SRC_B;
            end
            default: begin
                grant_vld = 1'b0;
                grant_src = SRC_A;
            end
        endcase
    end

    assign a_ready = !rst && load_ok && grant_vld && (grant_src == SRC_A);
    assign b_ready = !rst && load_ok && grant_vld && (grant_src == SRC_B);
    assign accept  = a_ready || b_ready;
    assign acc_src = b_ready ? SRC_B : SRC_A;
    assign acc_lock = b_ready ? b_lock : a_lock;

    // Mux select parks on its last value when nobody holds a grant.
    assign sel_mux  = rst ? 1'b0 : (grant_vld ? (grant_src == SRC_B) : sel_q);
    assign mux_data = sel_mux ? b_data : a_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_mux;
        end
    end

    // Arbiter FSM; everything is frozen while the output stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last      <= SRC_B;
            burst_cnt <= '0;
        end else if (accept) begin
            if (acc_lock && (burst_cnt < BURST_LAST)) begin
                state     <= (acc_src == SRC_A) ? ARB_LOCK_A : ARB_LOCK_B;
                burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                state     <= ARB_IDLE;
                burst_cnt <= '0;
                last      <= acc_src;
            end
        end else if (load_ok) begin
            // Locked owner went quiet: release without granting anyone this cycle.
            if (state == ARB_LOCK_A && !a_valid) begin
                state     <= ARB_IDLE;
                burst_cnt <= '0;
                last      <= SRC_A;
            end else if (state == ARB_LOCK_B && !b_valid) begin
                state     <= ARB_IDLE;
                burst_cnt <= '0;
                last      <= SRC_B;
            end
        end
    end

    arb_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (mux_data),
        .load_src  (acc_src),
        .out_ready (out_ready),
        .load_ok   (load_ok),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    assign busy = (state != ARB_IDLE) || out_valid;

endmodule
